// File: rtl/datareg_bank_if.sv
// Operation and read-port bundle for datareg_bank. The master drives the
// operation and read addresses; the slave (the bank) returns registered data and flags.
interface datareg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [2:0]        op_i;
  logic [WIDTH-1:0]  in_i;
  logic [ADDR_W-1:0] raddr_a_i;
  logic [ADDR_W-1:0] raddr_b_i;
  logic [WIDTH-1:0]  out_a_o;
  logic [WIDTH-1:0]  out_b_o;
  logic              c_o;
  logic              z_o;

  modport master (
    output we_i, waddr_i, op_i, in_i, raddr_a_i, raddr_b_i,
    input  out_a_o, out_b_o, c_o, z_o
  );

  modport slave (
    input  we_i, waddr_i, op_i, in_i, raddr_a_i, raddr_b_i,
    output out_a_o, out_b_o, c_o, z_o
  );
endinterface

// File: rtl/datareg_bank.sv
// Register bank of 2**ADDR_W data registers with a single ALU write port
// (load/inc/dec/shift/rotate/clear), carry and zero flags, and two forwarded read ports.
module datareg_bank #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  datareg_bank_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROTL = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Returns {carry, result} of one ALU operation on register value r.
  function automatic logic [WIDTH:0] exec_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] res;
    case (op)
      OP_LOAD: res = {1'b0, d};
      OP_INC:  res = {&r, r + ONE_W};
      OP_DEC:  res = {~|r, r - ONE_W};
      OP_SHL:  res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
      OP_SHR:  res = {r[0], 1'b0, r[WIDTH-1:1]};
      OP_ROTL: res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
      OP_CLR:  res = {1'b0, ZERO_W};
      default: res = {1'b0, r};
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] regs_r [NREG];
  logic [WIDTH-1:0] out_a_r;
  logic [WIDTH-1:0] out_b_r;
  logic             c_r;
  logic             z_r;

  logic             exec_s;
  logic [WIDTH-1:0] cur_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  // ALU result for the addressed register plus read data forwarded from that result.
  always_comb begin
    exec_s           = bus.we_i && (bus.op_i != OP_HOLD);
    cur_s            = regs_r[bus.waddr_i];
    {carry_s, res_s} = exec_op(bus.op_i, cur_s, bus.in_i);
    if (exec_s && (bus.raddr_a_i == bus.waddr_i)) begin
      rd_a_s = res_s;
    end else begin
      rd_a_s = regs_r[bus.raddr_a_i];
    end
    if (exec_s && (bus.raddr_b_i == bus.waddr_i)) begin
      rd_b_s = res_s;
    end else begin
      rd_b_s = regs_r[bus.raddr_b_i];
    end
  end

  // Register file, flags and read-port registers; reset discards any concurrent operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= ZERO_W;
      end
      out_a_r <= ZERO_W;
      out_b_r <= ZERO_W;
      c_r     <= 1'b0;
      z_r     <= 1'b0;
    end else begin
      if (exec_s) begin
        regs_r[bus.waddr_i] <= res_s;
        c_r                 <= carry_s;
        z_r                 <= ~|res_s;
      end
      out_a_r <= rd_a_s;
      out_b_r <= rd_b_s;
    end
  end

  assign bus.out_a_o = out_a_r;
  assign bus.out_b_o = out_b_r;
  assign bus.c_o     = c_r;
  assign bus.z_o     = z_r;
endmodule

// File: tb/tb_datareg_bank.sv
// Self-checking bench for datareg_bank: directed and random operations on an
// 8-bit/4-register and a 16-bit/8-register instance against an arithmetic model.
module tb_datareg_bank;
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst16 = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  datareg_bank_if #(.WIDTH(8),  .ADDR_W(2)) if8  ();
  datareg_bank_if #(.WIDTH(16), .ADDR_W(3)) if16 ();

  datareg_bank #(.WIDTH(8),  .ADDR_W(2)) u8  (.clk_i(clk), .rst_i(rst8),  .bus(if8));
  datareg_bank #(.WIDTH(16), .ADDR_W(3)) u16 (.clk_i(clk), .rst_i(rst16), .bus(if16));

  // Reference model: index 0 = 8-bit bank, index 1 = 16-bit bank
  int wid [2] = '{8, 16};
  int nreg[2] = '{4, 8};
  int mreg[2][8];
  int mc[2], mz[2], moa[2], mob[2];
  logic [31:0] got_a, got_b, got_c, got_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit rst, input bit we, input int wa,
                            input int op, input int din, input int ra, input int rb);
    int mask, r, res, c, w;
    w = wid[d];
    mask = (1 << w) - 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) mreg[d][i] = 0;
      mc[d] = 0; mz[d] = 0; moa[d] = 0; mob[d] = 0;
    end else begin
      if (we && op != 0) begin
        r = mreg[d][wa];
        c = 0;
        res = r;
        case (op)
          1: res = din & mask;
          2: begin res = (r + 1) & mask; c = (r == mask) ? 1 : 0; end
          3: begin res = (r - 1) & mask; c = (r == 0) ? 1 : 0; end
          4: begin res = (r * 2) & mask; c = (r >> (w - 1)) & 1; end
          5: begin res = r / 2; c = r % 2; end
          6: begin res = ((r * 2) & mask) | ((r >> (w - 1)) & 1); c = (r >> (w - 1)) & 1; end
          default: begin res = 0; c = 0; end
        endcase
        mreg[d][wa] = res;
        mc[d] = c;
        mz[d] = (res == 0) ? 1 : 0;
      end
      moa[d] = mreg[d][ra];
      mob[d] = mreg[d][rb];
    end
  endtask

  // One clock of stimulus on bank d; the other bank idles. Checks all outputs against the model.
  task automatic step(input int d, input bit rst, input bit we, input int wa, input int op,
                      input int din, input int ra, input int rb, input string tag);
    @(negedge clk);
    if (d == 0) begin
      rst8 = rst; rst16 = 1'b0; if16.we_i = 1'b0;
      if8.we_i = we; if8.waddr_i = wa[1:0]; if8.op_i = op[2:0]; if8.in_i = din[7:0];
      if8.raddr_a_i = ra[1:0]; if8.raddr_b_i = rb[1:0];
    end else begin
      rst16 = rst; rst8 = 1'b0; if8.we_i = 1'b0;
      if16.we_i = we; if16.waddr_i = wa[2:0]; if16.op_i = op[2:0]; if16.in_i = din[15:0];
      if16.raddr_a_i = ra[2:0]; if16.raddr_b_i = rb[2:0];
    end
    @(posedge clk);
    model_edge(d, rst, we, wa, op, din, ra, rb);
    #1;
    if (d == 0) begin
      got_a = {24'd0, if8.out_a_o}; got_b = {24'd0, if8.out_b_o};
      got_c = {31'd0, if8.c_o};     got_z = {31'd0, if8.z_o};
    end else begin
      got_a = {16'd0, if16.out_a_o}; got_b = {16'd0, if16.out_b_o};
      got_c = {31'd0, if16.c_o};     got_z = {31'd0, if16.z_o};
    end
    chk({tag, "_a"}, got_a, moa[d]);
    chk({tag, "_b"}, got_b, mob[d]);
    chk({tag, "_c"}, got_c, mc[d]);
    chk({tag, "_z"}, got_z, mz[d]);
  endtask

  initial begin
    int op, wa, d;
    if8.we_i = 1'b0;  if8.waddr_i = 2'd0;  if8.op_i = 3'd0;  if8.in_i = 8'd0;
    if8.raddr_a_i = 2'd0;  if8.raddr_b_i = 2'd0;
    if16.we_i = 1'b0; if16.waddr_i = 3'd0; if16.op_i = 3'd0; if16.in_i = 16'd0;
    if16.raddr_a_i = 3'd0; if16.raddr_b_i = 3'd0;

    // 8-bit bank: reset and directed scenarios
    step(0, 1, 0, 0, 0, 0, 0, 0, "rst8");
    chk("rst8_zero", got_a, 32'h0);
    step(0, 0, 1, 2, 1, 'hA5, 2, 0, "load_a5");
    chk("load_a5_out", got_a, 32'hA5);
    chk("load_a5_z", got_z, 32'h0);
    step(0, 0, 1, 1, 1, 'hFF, 1, 1, "load_ff");
    step(0, 0, 1, 1, 2, 0, 1, 1, "inc_ff");
    chk("inc_ff_out", got_a, 32'h00);
    chk("inc_ff_c", got_c, 32'h1);
    chk("inc_ff_z", got_z, 32'h1);
    step(0, 0, 1, 1, 3, 0, 1, 1, "dec_00");
    chk("dec_00_out", got_a, 32'hFF);
    chk("dec_00_c", got_c, 32'h1);
    step(0, 0, 1, 0, 1, 'h81, 0, 0, "load_81");
    step(0, 0, 1, 0, 4, 0, 0, 0, "shl_81");
    chk("shl_81_out", got_a, 32'h02);
    chk("shl_81_c", got_c, 32'h1);
    step(0, 0, 1, 0, 5, 0, 0, 0, "shr_02");
    chk("shr_02_out", got_a, 32'h01);
    chk("shr_02_c", got_c, 32'h0);
    step(0, 0, 1, 0, 1, 'h81, 0, 0, "load_81b");
    step(0, 0, 1, 0, 6, 0, 0, 0, "rotl_81");
    chk("rotl_81_out", got_a, 32'h03);
    chk("rotl_81_c", got_c, 32'h1);
    step(0, 0, 1, 3, 1, 'h7F, 0, 0, "load_7f");
    step(0, 0, 1, 3, 2, 0, 3, 3, "fwd_inc");
    chk("fwd_inc_a", got_a, 32'h80);
    chk("fwd_inc_b", got_b, 32'h80);
    chk("fwd_inc_c", got_c, 32'h0);
    step(0, 0, 1, 0, 1, 'h55, 0, 0, "load_55");
    step(0, 0, 0, 0, 7, 0, 0, 0, "we0_clr");
    chk("we0_clr_out", got_a, 32'h55);
    step(0, 1, 1, 2, 1, 'h12, 2, 2, "rst_load");
    chk("rst_load_out", got_a, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, i, 3 - i, "post_rst");

    // 16-bit bank: reset, wrap and top register
    step(1, 1, 0, 0, 0, 0, 0, 0, "rst16");
    step(1, 0, 1, 7, 1, 'hFFFF, 7, 7, "l16_ffff");
    step(1, 0, 1, 7, 2, 0, 7, 0, "inc16_ffff");
    chk("inc16_out", got_a, 32'h0);
    chk("inc16_c", got_c, 32'h1);
    step(1, 0, 1, 7, 3, 0, 7, 0, "dec16_0");
    chk("dec16_out", got_a, 32'hFFFF);
    step(1, 0, 1, 6, 1, 'h8001, 6, 6, "l16_8001");
    step(1, 0, 1, 6, 4, 0, 6, 7, "shl16");
    chk("shl16_out", got_a, 32'h0002);
    step(1, 0, 1, 6, 5, 0, 6, 7, "shr16");
    step(1, 0, 1, 6, 1, 'h8001, 6, 6, "l16_8001b");
    step(1, 0, 1, 6, 6, 0, 6, 7, "rotl16");
    chk("rotl16_out", got_a, 32'h0003);

    // Random operations on both banks, with occasional mid-sequence reset
    for (int n = 0; n < 400; n++) begin
      d  = n % 2;
      op = $urandom_range(7, 0);
      wa = $urandom_range(nreg[d] - 1, 0);
      step(d, ($urandom_range(39, 0) == 0), ($urandom_range(5, 0) != 0), wa, op,
           $urandom, $urandom_range(nreg[d] - 1, 0),
           ($urandom_range(2, 0) == 0) ? wa : $urandom_range(nreg[d] - 1, 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
